imul_radix: RTL
===============

IMUL_RADIX -- requirements
Module: imul_radix

Interface
REQ-001 SHALL have parameter ARCHBITSZ, default 32, operand width in bits; even, >= 8.
REQ-002 SHALL have parameter GPRCNT, default 32, GPR count; CLOG2GPRCNT = clog2(GPRCNT).
REQ-003 SHALL have parameter DIGITBITSZ, default 2, multiplier bits retired per cycle; one of 1, 2, 4; divides ARCHBITSZ.
REQ-004 SHALL have ports, in order:
- clk_i, input, 1, clock.
- rst_n_i, input, 1, asynchronous active-low reset.
- stb_i, input, 1, request strobe.
- data_i, input, 2*ARCHBITSZ+CLOG2GPRCNT+3, type[2:0] | gprid | multiplicand | multiplier.
- rdy_o, output, 1, ready to accept a request.
- ostb_i, input, 1, result consumed.
- data_o, output, ARCHBITSZ, result.
- gprid_o, output, CLOG2GPRCNT, destination GPR id.
- ordy_o, output, 1, result valid.
REQ-005 SHALL use one clock (clk_i); reset rst_n_i is asynchronous and active-low.
REQ-006 SHALL decode type: [0] 0/1 = low/high ARCHBITSZ of product; [1] multiplicand signed; [2] multiplier signed (types 011, 111, 101 give hsu/hss/hus variants).

Function
REQ-007 SHALL implement FSM IDLE -> BUSY -> DONE -> IDLE.
REQ-008 rdy_o SHALL be 1 only in IDLE; ordy_o SHALL be 1 only in DONE.
REQ-009 In IDLE, stb_i=1 SHALL capture data_i, enter BUSY, and clear digit counter; stb_i while rdy_o=0 is ignored.
REQ-010 Capture SHALL store absolute value of each operand flagged signed with msb set; most-negative value maps to unsigned 2^(ARCHBITSZ-1).
REQ-011 Capture SHALL register result sign = (a_signed & a_msb) XOR (b_signed & b_msb).
REQ-012 Each BUSY cycle SHALL add (digit x multiplier) to the upper accumulator half and shift the 2*ARCHBITSZ accumulator right DIGITBITSZ bits; digit = next DIGITBITSZ unexamined multiplicand bits.
REQ-013 Digit multiple SHALL be ARCHBITSZ+DIGITBITSZ bits wide; accumulation SHALL never carry beyond 2*ARCHBITSZ.
REQ-014 Without early exit, BUSY SHALL last exactly ARCHBITSZ/DIGITBITSZ cycles; ordy_o rises the next edge.
REQ-015 In DONE, data_o SHALL be low/high half per type[0] of the product, negated two's-complement over 2*ARCHBITSZ when sign=1; data_o and gprid_o SHALL stay stable until consumed.
REQ-016 ostb_i=1 in DONE SHALL return to IDLE next edge; ostb_i outside DONE is ignored.
REQ-017 Low-half result SHALL equal the low ARCHBITSZ bits of the true product for every type.

Reset
REQ-018 rst_n_i=0 SHALL immediately force IDLE: rdy_o=1, ordy_o=0, data_o=0, gprid_o=0, counter=0, accumulator=0.
REQ-019 Reset mid-BUSY or in DONE SHALL discard the operation; the first accept after release behaves as from power-up.

Configuration
REQ-020 With IMUL_RADIX_EARLYEXIT_EN defined, BUSY SHALL end once all unexamined multiplicand bits are zero, minimum 1 cycle; the accumulator is right-aligned by the skipped digits before DONE, giving a result identical to full iteration.
REQ-021 Without IMUL_RADIX_EARLYEXIT_EN, latency SHALL be the fixed value of REQ-014 and no alignment shifter SHALL exist.

Structure
REQ-022 Shared package imul_radix_pkg SHALL hold type-bit positions (IMULMSBRSLT, IMULASIGNED, IMULBSIGNED), IMULTYPEBITSZ=3, and FSM state encodings.
REQ-023 Sub-module imul_radix_digit SHALL compute the combinational digit multiple (0..2^DIGITBITSZ-1) x multiplier.

Verification (ARCHBITSZ=16, DIGITBITSZ=2 unless stated)
REQ-024 Test 1:
- Stimulus: 5 x 12, type 000.
- Response: data_o = 0x003C; ordy_o 9 edges after accept without EARLYEXIT.
REQ-025 Test 2:
- Stimulus: -3 x 7, types 011 and 010.
- Response: 0xFFFF and 0xFFEB.
REQ-026 Test 3:
- Stimulus: 0xFFFF x 0xFFFF, type 001.
- Response: 0xFFFE; same operands, type 111 -> 0x0000.
REQ-027 Test 4:
- Stimulus: 0x8000 x 0x8000, type 111.
- Response: 0x4000; type 011 with 0x8000 x 0x8000 -> 0xC000.
REQ-028 Test 5:
- Stimulus: EARLYEXIT on, 3 x 1 (multiplicand 3); repeat with 0 x 5.
- Response: DONE after 1 BUSY cycle each, data_o = 0x0003 and 0x0000; DIGITBITSZ=4 and 1 give the Test 1 results.
REQ-029 Test 6:
- Stimulus: rst_n_i pulse at BUSY cycle 4, then 2 x 3; separately hold ostb_i=0 for 5 cycles in DONE.
- Response: outputs at reset values, then 0x0006; data_o stable and rdy_o=0 while held.

Source files
------------

// File: rtl/imul_radix_pkg.sv
// rtl/imul_radix_pkg.sv - shared type-bit positions and FSM encoding for the radix multiplier
package imul_radix_pkg;

    localparam int IMULTYPEBITSZ = 3;
    localparam int IMULMSBRSLT   = 0;
    localparam int IMULASIGNED   = 1;
    localparam int IMULBSIGNED   = 2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } imul_state_e;

endpackage

// File: rtl/imul_radix_digit.sv
// rtl/imul_radix_digit.sv - combinational digit multiple: digit (0..2^DIGITBITSZ-1) x multiplier
module imul_radix_digit #(
    parameter int ARCHBITSZ  = 32,
    parameter int DIGITBITSZ = 2
) (
    input  logic [DIGITBITSZ-1:0]           digit_i,
    input  logic [ARCHBITSZ-1:0]            mplr_i,
    output logic [ARCHBITSZ+DIGITBITSZ-1:0] mult_o
);

    logic [ARCHBITSZ+DIGITBITSZ-1:0] mplr_ext;

    assign mplr_ext = {{DIGITBITSZ{1'b0}}, mplr_i};

    always_comb begin
        mult_o = '0;
        for (int i = 0; i < DIGITBITSZ; i++) begin
            if (digit_i[i]) begin
                mult_o = mult_o + (mplr_ext << i);
            end
        end
    end

endmodule

// File: rtl/imul_radix.sv
// rtl/imul_radix.sv - iterative radix-2^DIGITBITSZ integer multiplier with signed/unsigned variants
// Optional early termination on zero remaining multiplicand bits: IMUL_RADIX_EARLYEXIT_EN
module imul_radix
    import imul_radix_pkg::*;
#(
    parameter int ARCHBITSZ  = 32,
    parameter int GPRCNT     = 32,
    parameter int DIGITBITSZ = 2,
    localparam int CLOG2GPRCNT = $clog2(GPRCNT),
    localparam int DATABITSZ   = 2*ARCHBITSZ + CLOG2GPRCNT + IMULTYPEBITSZ
) (
    input  logic                   clk_i,
    input  logic                   rst_n_i,
    input  logic                   stb_i,
    input  logic [DATABITSZ-1:0]   data_i,
    output logic                   rdy_o,
    input  logic                   ostb_i,
    output logic [ARCHBITSZ-1:0]   data_o,
    output logic [CLOG2GPRCNT-1:0] gprid_o,
    output logic                   ordy_o
);

    localparam int NDIGITS  = ARCHBITSZ / DIGITBITSZ;
    localparam int CNTBITSZ = $clog2(NDIGITS + 1);
    localparam logic [CNTBITSZ-1:0] LASTCNT = CNTBITSZ'(NDIGITS - 1);

    imul_state_e                state_q, state_d;
    logic [2*ARCHBITSZ-1:0]     acc_q, acc_d;
    logic [ARCHBITSZ-1:0]       a_q, a_d;
    logic [ARCHBITSZ-1:0]       b_q, b_d;
    logic [CNTBITSZ-1:0]        cnt_q, cnt_d;
    logic                       sign_q, sign_d;
    logic                       msb_q, msb_d;
    logic [CLOG2GPRCNT-1:0]     gprid_q, gprid_d;
    logic [ARCHBITSZ-1:0]       res_q, res_d;

    logic [IMULTYPEBITSZ-1:0]   in_type;
    logic [ARCHBITSZ-1:0]       in_a, in_b;
    logic                       in_a_neg, in_b_neg;

    logic [ARCHBITSZ+DIGITBITSZ-1:0]   mult;
    logic [ARCHBITSZ+DIGITBITSZ-1:0]   sum;
    logic [2*ARCHBITSZ+DIGITBITSZ-1:0] acc_wide;
    logic [2*ARCHBITSZ-1:0]            acc_step, acc_fin, acc_sgn;
    logic [ARCHBITSZ-1:0]              a_next;
    logic                              last;

    assign in_type  = data_i[DATABITSZ-1 -: IMULTYPEBITSZ];
    assign in_a     = data_i[ARCHBITSZ +: ARCHBITSZ];
    assign in_b     = data_i[0 +: ARCHBITSZ];
    assign in_a_neg = in_type[IMULASIGNED] & in_a[ARCHBITSZ-1];
    assign in_b_neg = in_type[IMULBSIGNED] & in_b[ARCHBITSZ-1];

    imul_radix_digit #(
        .ARCHBITSZ  (ARCHBITSZ),
        .DIGITBITSZ (DIGITBITSZ)
    ) u_digit (
        .digit_i (a_q[DIGITBITSZ-1:0]),
        .mplr_i  (b_q),
        .mult_o  (mult)
    );

    // The upper half plus one digit multiple always fits in ARCHBITSZ+DIGITBITSZ bits.
    assign sum      = {{DIGITBITSZ{1'b0}}, acc_q[2*ARCHBITSZ-1:ARCHBITSZ]} + mult;
    assign acc_wide = {sum, acc_q[ARCHBITSZ-1:0]};
    assign acc_step = acc_wide[2*ARCHBITSZ+DIGITBITSZ-1:DIGITBITSZ];
    assign a_next   = a_q >> DIGITBITSZ;

`ifdef IMUL_RADIX_EARLYEXIT_EN
    // Skipped digits would each have shifted the accumulator right once more.
    assign last    = (cnt_q == LASTCNT) || (a_next == '0);
    assign acc_fin = acc_step >> (DIGITBITSZ * (NDIGITS - 1 - int'(cnt_q)));
`else
    assign last    = (cnt_q == LASTCNT);
    assign acc_fin = acc_step;
`endif

    assign acc_sgn = sign_q ? (~acc_fin + 1'b1) : acc_fin;

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        a_d     = a_q;
        b_d     = b_q;
        cnt_d   = cnt_q;
        sign_d  = sign_q;
        msb_d   = msb_q;
        gprid_d = gprid_q;
        res_d   = res_q;
        unique case (state_q)
            ST_IDLE: begin
                if (stb_i) begin
                    state_d = ST_BUSY;
                    acc_d   = '0;
                    cnt_d   = '0;
                    a_d     = in_a_neg ? (~in_a + 1'b1) : in_a;
                    b_d     = in_b_neg ? (~in_b + 1'b1) : in_b;
                    sign_d  = in_a_neg ^ in_b_neg;
                    msb_d   = in_type[IMULMSBRSLT];
                    gprid_d = data_i[2*ARCHBITSZ +: CLOG2GPRCNT];
                end
            end
            ST_BUSY: begin
                acc_d = acc_step;
                a_d   = a_next;
                cnt_d = cnt_q + 1'b1;
                if (last) begin
                    state_d = ST_DONE;
                    acc_d   = acc_fin;
                    res_d   = msb_q ? acc_sgn[2*ARCHBITSZ-1:ARCHBITSZ] : acc_sgn[ARCHBITSZ-1:0];
                end
            end
            ST_DONE: begin
                if (ostb_i) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= ST_IDLE;
            acc_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            cnt_q   <= '0;
            sign_q  <= 1'b0;
            msb_q   <= 1'b0;
            gprid_q <= '0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            a_q     <= a_d;
            b_q     <= b_d;
            cnt_q   <= cnt_d;
            sign_q  <= sign_d;
            msb_q   <= msb_d;
            gprid_q <= gprid_d;
            res_q   <= res_d;
        end
    end

    assign rdy_o   = (state_q == ST_IDLE);
    assign ordy_o  = (state_q == ST_DONE);
    assign data_o  = res_q;
    assign gprid_o = gprid_q;

endmodule
